// File: rtl/cic_norm_gain.sv
// CIC gain normalizer: scales the decimator output by round(2^F/(r*M)^N) and narrows it to WIDTH bits.
// Optional macro CIC_NORM_SATURATE_EN clamps out-of-range results; by default they wrap.
module cic_norm_gain #(
    parameter int WIDTH      = 16,
    parameter int RMAX       = 4,
    parameter int M          = 1,
    parameter int N          = 2,
    parameter int REG_WIDTH  = WIDTH + $clog2((RMAX*M)**N),
    parameter int COEF_WIDTH = 18
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [REG_WIDTH-1:0]         input_tdata,
    input  logic                         input_tvalid,
    output logic                         input_tready,
    output logic [WIDTH-1:0]             output_tdata,
    output logic                         output_tvalid,
    input  logic                         output_tready,
    input  logic [$clog2(RMAX+1)-1:0]    rate
);
    localparam int F     = COEF_WIDTH - 1;
    localparam int RW    = $clog2(RMAX+1);
    localparam int GW    = $clog2((RMAX*M)**N) + 1;
    localparam int CNT_W = $clog2(COEF_WIDTH + N + 1);
    localparam int PW    = REG_WIDTH + COEF_WIDTH + 1;
    localparam int YW    = PW + 1 - F;

    localparam logic signed [PW:0]   HALF = {{(PW+1-F){1'b0}}, 1'b1, {(F-1){1'b0}}};
    localparam logic signed [YW-1:0] YMAX = {{(YW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [YW-1:0] YMIN = {{(YW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, POWER, DIVIDE, RUN, DRAIN} state_t;

    state_t state, state_nx;

    logic [RW-1:0]         rate_reg, r_eff;
    logic [GW-1:0]         g, rm, g_mul, rem;
    logic [CNT_W-1:0]      cnt;
    logic [COEF_WIDTH-2:0] q;
    logic [COEF_WIDTH-1:0] k, dvd;
    logic [GW:0]           rem_sh, rem_nx;
    logic                  q_bit;

    logic                         en, pipe_empty, load_cfg;
    logic                         v1, v2;
    logic signed [REG_WIDTH-1:0]  x1;
    logic signed [COEF_WIDTH:0]   k_s;
    logic signed [PW-1:0]         prod, p2;
    logic signed [PW:0]           rnd;
    logic signed [YW-1:0]         y;
    logic [WIDTH-1:0]             y_nar;

    // ---------------- coefficient engine ----------------
    assign r_eff  = (rate_reg == '0) ? RW'(1) : rate_reg;
    assign rm     = GW'(r_eff) * GW'(M);
    assign g_mul  = g * rm;
    assign dvd    = ({{(COEF_WIDTH-1){1'b0}}, 1'b1} << F) + COEF_WIDTH'(g >> 1);
    // restoring division: shift in the next dividend bit, subtract G when it fits
    assign rem_sh = {rem, dvd[cnt]};
    assign q_bit  = rem_sh >= {1'b0, g};
    assign rem_nx = q_bit ? (rem_sh - {1'b0, g}) : rem_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = POWER;
            POWER:   if (cnt == CNT_W'(N-1)) state_nx = DIVIDE;
            DIVIDE:  if (cnt == '0) state_nx = RUN;
            RUN:     if (rate != rate_reg) state_nx = DRAIN;
            DRAIN:   if (pipe_empty) state_nx = POWER;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        en           = !output_tvalid || output_tready;
        pipe_empty   = !v1 && !v2 && !output_tvalid;
        input_tready = (state == RUN) && en && (rate == rate_reg);
        load_cfg     = (state == IDLE) || ((state == DRAIN) && pipe_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_reg <= '0;
            g        <= '0;
            cnt      <= '0;
            rem      <= '0;
            q        <= '0;
            k        <= '0;
        end else if (load_cfg) begin
            rate_reg <= rate;
            g        <= GW'(1);
            cnt      <= '0;
        end else if (state == POWER) begin
            g <= g_mul;
            if (cnt == CNT_W'(N-1)) begin
                cnt <= CNT_W'(COEF_WIDTH-1);
                rem <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (state == DIVIDE) begin
            rem <= rem_nx[GW-1:0];
            q   <= {q[COEF_WIDTH-3:0], q_bit};
            if (cnt == '0) k <= {q, q_bit};
            else           cnt <= cnt - CNT_W'(1);
        end
    end

    // ---------------- streaming pipeline ----------------
    assign k_s  = signed'({1'b0, k});
    assign prod = PW'(x1) * PW'(k_s);
    assign rnd  = {p2[PW-1], p2} + HALF;
    assign y    = rnd[PW:F];

`ifdef CIC_NORM_SATURATE_EN
    always_comb begin
        if (y > YMAX)      y_nar = YMAX[WIDTH-1:0];
        else if (y < YMIN) y_nar = YMIN[WIDTH-1:0];
        else               y_nar = y[WIDTH-1:0];
    end
    wire unused_bits = &{1'b0, rnd[F-1:0], rem_nx[GW]};
`else
    assign y_nar = y[WIDTH-1:0];
    wire unused_bits = &{1'b0, rnd[F-1:0], y[YW-1:WIDTH], rem_nx[GW], YMAX, YMIN};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            output_tvalid <= 1'b0;
            x1            <= '0;
            p2            <= '0;
            output_tdata  <= '0;
        end else if (en) begin
            v1            <= input_tvalid && input_tready;
            x1            <= input_tdata;
            v2            <= v1;
            p2            <= prod;
            output_tvalid <= v2;
            output_tdata  <= y_nar;
        end
    end
endmodule
